// File: rtl/armleocpu_icache_lite.sv
// armleocpu_icache_lite
//   Instruction-side responder for the fetch unit on MMU-less configurations.
//   Serves EXECUTE from a direct-mapped buffer of 2^ENTRIES_W one-word
//   entries, refills misses over a single-beat memory read port and
//   implements FLUSH_ALL. Never reports PAGEFAULT.
//
// Ports
//   clk, rst         single clock, synchronous active-high reset
//   c_cmd            fetch unit command (CACHE_CMD_* encoding)
//   c_address        fetch address, sampled when a command is accepted
//   c_response       registered CACHE_RESPONSE_* result
//   c_load_data      instruction word while c_response==DONE, else 0
//   c_reset_done     high once the reset invalidation walk is over
//   m_req/m_addr     memory read request, held until m_ack
//   m_ack/m_rdata/m_err  one-cycle completion strobe with data/bus error
module armleocpu_icache_lite #(
  parameter int          ENTRIES_W = 4,
  parameter logic [31:0] ADDR_LO   = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  c_cmd,
  input  logic [31:0] c_address,
  output logic [3:0]  c_response,
  output logic [31:0] c_load_data,
  output logic        c_reset_done,
  output logic        m_req,
  output logic [31:0] m_addr,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  input  logic        m_err
);

  // Encodings shared with armleocpu_cache.vh
  localparam logic [3:0] CMD_NONE      = 4'd0;
  localparam logic [3:0] CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CMD_FLUSH_ALL = 4'd4;

  localparam logic [3:0] RESP_IDLE        = 4'd0;
  localparam logic [3:0] RESP_WAIT        = 4'd1;
  localparam logic [3:0] RESP_DONE        = 4'd2;
  localparam logic [3:0] RESP_ACCESSFAULT = 4'd3;
  localparam logic [3:0] RESP_MISSALIGNED = 4'd5;

  localparam int ENTRIES = 1 << ENTRIES_W;
  localparam int TAG_W   = 32 - ENTRIES_W - 2;

  typedef enum logic [1:0] {
    S_INIT,
    S_READY,
    S_REFILL,
    S_FLUSH
  } state_t;

  state_t                 state, state_nxt;
  logic [ENTRIES_W-1:0]   walk_cnt, walk_cnt_nxt;
  logic [3:0]             resp_nxt;
  logic [31:0]            data_nxt;
  logic                   reset_done_nxt;
  logic                   m_req_nxt;
  logic [31:0]            m_addr_nxt;
  logic                   fill_we;
  logic                   clr_we;

  // Storage
  logic [ENTRIES-1:0]     valid;
  logic [TAG_W-1:0]       tag_mem  [ENTRIES];
  logic [31:0]            data_mem [ENTRIES];

  // Lookup for the incoming command
  logic [ENTRIES_W-1:0]   cmd_idx;
  logic [TAG_W-1:0]       cmd_tag;
  logic                   cmd_hit;
  logic                   cmd_misaligned;

  assign cmd_idx        = c_address[ENTRIES_W+1:2];
  assign cmd_tag        = c_address[31:ENTRIES_W+2];
  assign cmd_hit        = valid[cmd_idx] && (tag_mem[cmd_idx] == cmd_tag);
  assign cmd_misaligned = (c_address[1:0] != 2'b00);

  // Range check by 33-bit subtraction: the borrow bit tells which side of
  // the bound the address is on. Plain compares against the default
  // 0 / all-ones bounds would fold to constants.
  logic        below_lo, above_hi;
  logic [31:0] unused_lo_diff, unused_hi_diff;
  logic        cmd_out_of_range;

  assign {below_lo, unused_lo_diff} = {1'b0, c_address} - {1'b0, ADDR_LO};
  assign {above_hi, unused_hi_diff} = {1'b0, ADDR_HI} - {1'b0, c_address};
  assign cmd_out_of_range = below_lo | above_hi;

  // Refill target is always the latched request address
  logic [ENTRIES_W-1:0]   fill_idx;
  logic [TAG_W-1:0]       fill_tag;

  assign fill_idx = m_addr[ENTRIES_W+1:2];
  assign fill_tag = m_addr[31:ENTRIES_W+2];

  // Next-state / next-output logic. c_response and c_load_data default to
  // IDLE/0 so every result is shown for exactly one cycle.
  always_comb begin
    state_nxt      = state;
    walk_cnt_nxt   = walk_cnt;
    resp_nxt       = RESP_IDLE;
    data_nxt       = 32'h0;
    reset_done_nxt = c_reset_done;
    m_req_nxt      = m_req;
    m_addr_nxt     = m_addr;
    fill_we        = 1'b0;
    clr_we         = 1'b0;

    case (state)
      S_INIT: begin
        // Commands ignored; one valid bit cleared per cycle
        clr_we       = 1'b1;
        walk_cnt_nxt = walk_cnt + 1'b1;
        if (walk_cnt == '1) begin
          state_nxt      = S_READY;
          reset_done_nxt = 1'b1;
        end
      end

      S_READY: begin
        case (c_cmd)
          CMD_EXECUTE: begin
            if (cmd_misaligned) begin
              resp_nxt = RESP_MISSALIGNED;
            end else if (cmd_out_of_range) begin
              resp_nxt = RESP_ACCESSFAULT;
            end else if (cmd_hit) begin
              resp_nxt = RESP_DONE;
              data_nxt = data_mem[cmd_idx];
            end else begin
              state_nxt  = S_REFILL;
              resp_nxt   = RESP_WAIT;
              m_req_nxt  = 1'b1;
              m_addr_nxt = c_address;
            end
          end
          CMD_FLUSH_ALL: begin
            state_nxt    = S_FLUSH;
            resp_nxt     = RESP_WAIT;
            walk_cnt_nxt = '0;
          end
          default: begin
            resp_nxt = RESP_IDLE;
          end
        endcase
      end

      S_REFILL: begin
        // Re-presented EXECUTE during WAIT has no effect
        resp_nxt = RESP_WAIT;
        if (m_ack) begin
          state_nxt = S_READY;
          m_req_nxt = 1'b0;
          if (m_err) begin
            resp_nxt = RESP_ACCESSFAULT;
          end else begin
            fill_we  = 1'b1;
            resp_nxt = RESP_DONE;
            data_nxt = m_rdata;
          end
        end
      end

      S_FLUSH: begin
        // Held FLUSH_ALL during WAIT has no effect
        resp_nxt     = RESP_WAIT;
        clr_we       = 1'b1;
        walk_cnt_nxt = walk_cnt + 1'b1;
        if (walk_cnt == '1) begin
          state_nxt = S_READY;
          resp_nxt  = RESP_DONE;
        end
      end

      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_INIT;
      walk_cnt     <= '0;
      c_response   <= RESP_IDLE;
      c_load_data  <= 32'h0;
      c_reset_done <= 1'b0;
      m_req        <= 1'b0;
      m_addr       <= 32'h0;
    end else begin
      state        <= state_nxt;
      walk_cnt     <= walk_cnt_nxt;
      c_response   <= resp_nxt;
      c_load_data  <= data_nxt;
      c_reset_done <= reset_done_nxt;
      m_req        <= m_req_nxt;
      m_addr       <= m_addr_nxt;
    end
  end

  // Storage updates. Validity is cleared only by the INIT/FLUSH walk, so a
  // reset asserted mid-walk simply restarts it from entry 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        valid[walk_cnt] <= 1'b0;
      end else if (fill_we) begin
        valid[fill_idx]    <= 1'b1;
        tag_mem[fill_idx]  <= fill_tag;
        data_mem[fill_idx] <= m_rdata;
      end
    end
  end

  // CMD_NONE is handled by the default arm; keep it named for readers.
  logic unused_cmd_none;
  assign unused_cmd_none = (c_cmd == CMD_NONE);

endmodule

// File: tb/tb_armleocpu_icache_lite.sv
module tb_armleocpu_icache_lite;

  localparam logic [3:0] CMD_NONE  = 4'd0;
  localparam logic [3:0] CMD_EXEC  = 4'd1;
  localparam logic [3:0] CMD_FLUSH = 4'd4;
  localparam logic [3:0] R_IDLE = 4'd0;
  localparam logic [3:0] R_WAIT = 4'd1;
  localparam logic [3:0] R_DONE = 4'd2;
  localparam logic [3:0] R_AF   = 4'd3;
  localparam logic [3:0] R_MIS  = 4'd5;
  localparam logic [31:0] HI = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  c_cmd = CMD_NONE;
  logic [31:0] c_address = 32'h0;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic        c_reset_done;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  armleocpu_icache_lite #(
    .ENTRIES_W (4),
    .ADDR_LO   (32'h0000_0000),
    .ADDR_HI   (HI)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .c_cmd        (c_cmd),
    .c_address    (c_address),
    .c_response   (c_response),
    .c_load_data  (c_load_data),
    .c_reset_done (c_reset_done),
    .m_req        (m_req),
    .m_addr       (m_addr),
    .m_ack        (m_ack),
    .m_rdata      (m_rdata),
    .m_err        (m_err)
  );

  int passed = 0;
  int total  = 0;

  // Reference: which full word address each slot holds and its word
  bit          mvalid [16];
  logic [31:0] maddr  [16];
  logic [31:0] mdata  [16];

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h2000) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  // Reset for one edge, then watch the 16-cycle walk with EXECUTE held
  task automatic do_reset;
    rst = 1'b1;
    m_ack = 1'b0;
    c_cmd = CMD_EXEC;
    c_address = 32'h2000;
    tick;
    check("rst_resp", c_response, R_IDLE);
    check("rst_data", c_load_data, 32'h0);
    check("rst_done", c_reset_done, 0);
    check("rst_mreq", m_req, 0);
    check("rst_maddr", m_addr, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("walk_done", c_reset_done, 0);
      check("walk_resp", c_response, R_IDLE);
      check("walk_mreq", m_req, 0);
      tick;
    end
    check("walk_done_rise", c_reset_done, 1);
    check("walk_end_resp", c_response, R_IDLE);
    c_cmd = CMD_NONE;
    model_clear();
  endtask

  // One EXECUTE; predicts the outcome from the reference and plays the bus
  task automatic exec(input logic [31:0] a, input int dly, input bit err);
    logic [3:0]  er;
    logic [31:0] ed;
    logic [3:0]  idx;
    bit          miss;
    idx  = a[5:2];
    miss = 1'b0;
    ed   = 32'h0;
    if (a[1:0] != 2'b00) er = R_MIS;
    else if (a > HI) er = R_AF;
    else if (mvalid[idx] && maddr[idx] == a) begin er = R_DONE; ed = mdata[idx]; end
    else begin miss = 1'b1; er = R_WAIT; end
    c_cmd = CMD_EXEC;
    c_address = a;
    tick;
    if (!miss) begin
      c_cmd = CMD_NONE;
      check("imm_resp", c_response, er);
      check("imm_data", c_load_data, ed);
      check("imm_mreq", m_req, 0);
    end else begin
      // EXECUTE stays presented during WAIT, as the fetch unit does
      for (int k = 0; k <= dly; k++) begin
        check("wait_resp", c_response, R_WAIT);
        check("wait_data", c_load_data, 32'h0);
        check("wait_mreq", m_req, 1);
        check("wait_maddr", m_addr, a);
        m_rdata = $urandom;
        if (k == dly) begin
          m_ack = 1'b1;
          m_err = err;
          m_rdata = memw(a);
        end
        tick;
      end
      m_ack = 1'b0;
      m_err = 1'b0;
      c_cmd = CMD_NONE;
      check("fill_resp", c_response, err ? R_AF : R_DONE);
      check("fill_data", c_load_data, err ? 32'h0 : memw(a));
      check("fill_mreq", m_req, 0);
      if (!err) begin
        mvalid[idx] = 1'b1;
        maddr[idx]  = a;
        mdata[idx]  = memw(a);
      end
    end
  endtask

  // FLUSH_ALL held through WAIT
  task automatic flush;
    c_cmd = CMD_FLUSH;
    tick;
    for (int k = 0; k < 16; k++) begin
      check("flush_wait", c_response, R_WAIT);
      check("flush_mreq", m_req, 0);
      tick;
    end
    c_cmd = CMD_NONE;
    check("flush_done", c_response, R_DONE);
    model_clear();
  endtask

  task automatic idle_check;
    c_cmd = CMD_NONE;
    tick;
    check("idle_resp", c_response, R_IDLE);
    check("idle_data", c_load_data, 32'h0);
  endtask

  initial begin
    model_clear();
    do_reset();

    // Cold miss with 3 bus wait cycles, then hit, then replacement
    exec(32'h2000, 3, 1'b0);
    idle_check();
    exec(32'h2000, 0, 1'b0);
    exec(32'h2040, 1, 1'b0);
    exec(32'h2000, 0, 1'b0);
    idle_check();

    // Error priorities and range boundary
    exec(32'h2002, 0, 1'b0);
    exec(32'h0001_0000, 0, 1'b0);
    exec(32'h0001_0002, 0, 1'b0);
    exec(32'h0000_FFFC, 0, 1'b0);
    exec(32'h0000_FFFC, 0, 1'b0);

    // Bus error leaves no fill
    exec(32'h3000, 2, 1'b1);
    exec(32'h3000, 0, 1'b0);
    exec(32'h3000, 0, 1'b0);

    // Flush then re-miss
    exec(32'h2000, 0, 1'b0);
    flush();
    exec(32'h2000, 1, 1'b0);

    // Reset in the middle of a refill
    c_cmd = CMD_EXEC;
    c_address = 32'h2080;
    tick;
    check("midrst_wait", c_response, R_WAIT);
    check("midrst_mreq", m_req, 1);
    tick;
    do_reset();
    exec(32'h2000, 0, 1'b0);

    // Randomised traffic against the reference
    for (int n = 0; n < 120; n++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) flush();
      else if (r == 1) exec(32'h2000 + ($urandom_range(0, 47) * 4) + $urandom_range(1, 3), 0, 1'b0);
      else if (r == 2) exec(32'h0001_0000 + ($urandom_range(0, 1023) * 4), 0, 1'b0);
      else if (r == 3) idle_check();
      else exec(32'h2000 + ($urandom_range(0, 47) * 4), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0));
    end
    idle_check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
